// File: rtl/mem_req_arbiter.sv
// Round-robin, packet-atomic arbiter that merges N_REQ AXIS-style request
// lanes into one memory request lane. It tracks every forwarded read in a
// tag FIFO so that the single-beat read responses can be steered back, in
// order, to the requester that issued them.
module mem_req_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned TAG_DEPTH = 16,
  parameter int unsigned DATA_W    = 128
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [DATA_W-1:0]               req_axis_data  [N_REQ],
  input  logic                            req_axis_tuser [N_REQ],
  input  logic                            req_axis_valid [N_REQ],
  output logic                            req_axis_ready [N_REQ],
  output logic [DATA_W-1:0]               out_axis_data,
  output logic                            out_axis_tuser,
  output logic                            out_axis_valid,
  input  logic                            out_axis_ready,
  input  logic [DATA_W-1:0]               in_axis_data,
  input  logic                            in_axis_tuser,
  input  logic                            in_axis_valid,
  output logic                            in_axis_ready,
  output logic [DATA_W-1:0]               resp_axis_data  [N_REQ],
  output logic                            resp_axis_tuser [N_REQ],
  output logic                            resp_axis_valid [N_REQ],
  input  logic                            resp_axis_ready [N_REQ],
  output logic [$clog2(TAG_DEPTH+1)-1:0]  outstanding,
  output logic                            proto_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_DATA
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] g;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;

  logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head_tag;
  logic             fifo_empty;
  logic             fifo_full;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] stray;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] scan_idx;

  logic             out_hs;
  logic             push;
  logic             pop;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(TAG_DEPTH));
  assign head_tag    = tag_mem[rd_ptr];
  assign outstanding = count;
  assign next_ptr    = (32'(g) == N_REQ - 1) ? '0 : g + IDX_W'(1);

  assign out_hs = out_axis_valid & out_axis_ready;
  assign push   = (state == S_HEAD) & out_hs & ~out_axis_data[0];
  assign pop    = in_axis_valid & in_axis_ready;

  // Per-requester grant eligibility; a read header needs a free tag slot.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = req_axis_valid[i] & req_axis_tuser[i] &
                    (req_axis_data[i][0] | ~fifo_full);
      stray[i]    = req_axis_valid[i] & ~req_axis_tuser[i];
    end
  end

  // Round-robin scan starting at rr_ptr; first eligible index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = IDX_W'((32'(rr_ptr) + k) % N_REQ);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Request passthrough from the granted requester while a packet is open.
  always_comb begin
    out_axis_data  = req_axis_data[g];
    out_axis_tuser = req_axis_tuser[g];
    out_axis_valid = (state != S_IDLE) & req_axis_valid[g];
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_axis_ready[i] = (state != S_IDLE) && (IDX_W'(i) == g) && out_axis_ready;
    end
  end

  // Response steering to the requester at the head of the tag FIFO.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      resp_axis_data[i]  = in_axis_data;
      resp_axis_tuser[i] = in_axis_tuser;
      resp_axis_valid[i] = in_axis_valid & ~fifo_empty & (head_tag == IDX_W'(i));
    end
    in_axis_ready = ~fifo_empty & resp_axis_ready[head_tag];
  end

  // Grant FSM, round-robin pointer and sticky protocol error flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      g         <= '0;
      rr_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      if ((state == S_IDLE) && (|stray)) proto_err <= 1'b1;
      if (in_axis_valid && fifo_empty) proto_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            g     <= win_idx;
            state <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (out_hs) begin
            if (out_axis_data[0]) begin
              state <= S_DATA;
            end else begin
              rr_ptr <= next_ptr;
              state  <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (out_hs) begin
            // A header-flagged beat here is still forwarded as the data beat.
            if (out_axis_tuser) proto_err <= 1'b1;
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag FIFO of requester indices for in-flight reads.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= g;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
